mul_booth_wallace_pipe: RTL and testbench



---
 rtl/mul_booth_wallace_pipe_pkg.sv | 25 ++
 rtl/booth_pp_switch.sv | 40 ++++
 rtl/wallace_tree_.sv | 61 ++++++
 rtl/mul_booth_wallace_pipe.sv | 99 +++++++++
 tb/tb_mul_booth_wallace_pipe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_booth_wallace_pipe_pkg.sv
// mul_pkg: shared widths, opcode encoding and pipeline register layout for
// the Booth/Wallace multiplier (mul_booth_wallace_pipe).
package mul_pkg;
  localparam int XLEN    = 32;        // operand width
  localparam int PP_N    = XLEN + 1;  // Booth partial-product rows
  localparam int COL_N   = 2 * XLEN;  // product columns
  localparam int CARRY_N = 30;        // carries passed column-to-column by wallace_tree_

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef logic [COL_N-1:0] pp_row_t;

  // Stage-1 register: redundant (sum, carry, Booth +1) form of the product.
  typedef struct packed {
    pp_row_t s;
    pp_row_t c;
    pp_row_t k;
    mul_op_t op;
  } s1_reg_t;
endpackage

// File: rtl/booth_pp_switch.sv
// booth_pp_switch: operand extension, radix-2 Booth recoding, 33-row
// partial-product generation and transpose into per-column bit vectors.
// Ports: op         - RV32M multiply opcode
//        src1, src2 - multiplicand / multiplier
//        cols[j]    - bit j of every row (input to column compressor j)
//        k          - Booth +1 correction, bit i set when row i is negated
module booth_pp_switch
  import mul_pkg::*;
(
  input  mul_op_t                      op,
  input  logic [XLEN-1:0]              src1,
  input  logic [XLEN-1:0]              src2,
  output logic [COL_N-1:0][PP_N-1:0]   cols,
  output pp_row_t                      k
);
  logic [PP_N-1:0] x, y, sel;
  logic [PP_N:0]   yb;  // y with the implicit y[-1]=0 appended
  pp_row_t         rows [PP_N];

  always_comb begin
    x    = {((op == OP_MULH) || (op == OP_MULHSU)) & src1[XLEN-1], src1};
    y    = {(op == OP_MULH) & src2[XLEN-1], src2};
    yb   = {y, 1'b0};
    k    = '0;
    cols = '0;
    sel  = '0;
    for (int i = 0; i < PP_N; i++) begin
      case ({yb[i+1], yb[i]})
        2'b01:   sel = x;
        2'b10:   begin sel = ~x; k[i] = 1'b1; end
        default: sel = '0;
      endcase
      // Sign-extend to full width, then weight by 2^i; overflow past the top column is dropped.
      rows[i] = pp_row_t'({{(COL_N-PP_N){sel[PP_N-1]}}, sel}) << i;
    end
    for (int j = 0; j < COL_N; j++)
      for (int i = 0; i < PP_N; i++)
        cols[j][i] = rows[i][j];
  end
endmodule

// File: rtl/wallace_tree_.sv
// wallace_tree_: single-column 33-input carry-save compressor.
// Ports: a      - the 33 partial-product bits of this column
//        c_in   - 30 carries from the column below (weight 1 here)
//        c_out  - 30 carries into the column above
//        s, c   - residual sum (weight 1) and carry (weight 2)
// Invariant: popcount(a) + popcount(c_in) = s + 2*c + 2*popcount(c_out).
// Incoming carries join at successive levels, so the cross-column path is
// bounded by tree depth rather than by column count.
module wallace_tree_ (
  input  logic [32:0] a,
  input  logic [29:0] c_in,
  output logic [29:0] c_out,
  output logic        s,
  output logic        c
);
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  logic [10:0] l1;
  logic [21:0] v2;
  logic [7:0]  l2;
  logic [14:0] v3;
  logic [4:0]  l3;
  logic [9:0]  v4;
  logic [3:0]  l4;
  logic [6:0]  v5;
  logic [2:0]  l5;
  logic [4:0]  v6;
  logic [2:0]  l6;
  logic [3:0]  v7;
  logic [1:0]  l7;
  logic [2:0]  v8;

  always_comb begin
    c_out = '0;
    l1 = '0; l2 = '0; l3 = '0; l4 = '0; l5 = '0; l6 = '0; l7 = '0;
    s = 1'b0;
    c = 1'b0;
    for (int k = 0; k < 11; k++) {c_out[k], l1[k]} = fa(a[3*k], a[3*k+1], a[3*k+2]);
    v2 = {c_in[10:0], l1};
    for (int k = 0; k < 7; k++) {c_out[11+k], l2[k]} = fa(v2[3*k], v2[3*k+1], v2[3*k+2]);
    l2[7] = v2[21];
    v3 = {c_in[17:11], l2};
    for (int k = 0; k < 5; k++) {c_out[18+k], l3[k]} = fa(v3[3*k], v3[3*k+1], v3[3*k+2]);
    v4 = {c_in[22:18], l3};
    for (int k = 0; k < 3; k++) {c_out[23+k], l4[k]} = fa(v4[3*k], v4[3*k+1], v4[3*k+2]);
    l4[3] = v4[9];
    v5 = {c_in[25:23], l4};
    for (int k = 0; k < 2; k++) {c_out[26+k], l5[k]} = fa(v5[3*k], v5[3*k+1], v5[3*k+2]);
    l5[2] = v5[6];
    v6 = {c_in[27:26], l5};
    {c_out[28], l6[0]} = fa(v6[0], v6[1], v6[2]);
    l6[2:1] = v6[4:3];
    v7 = {c_in[28], l6};
    {c_out[29], l7[0]} = fa(v7[0], v7[1], v7[2]);
    l7[1] = v7[3];
    v8 = {c_in[29], l7};
    {c, s} = fa(v8[0], v8[1], v8[2]);
  end
endmodule

// File: rtl/mul_booth_wallace_pipe.sv
// mul_booth_wallace_pipe: 2-stage 32x32 RV32M multiplier
// (MUL/MULH/MULHSU/MULHU) with valid/ready on both sides.
//   Stage 1: Booth rows -> 64 chained wallace_tree_ columns -> register S,C,K,op.
//   Stage 2: S + (C<<1) + K via a 3:2 row and one 64-bit add -> registered result.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_op/in_src1/in_src2
//        request side; out_valid/out_ready/out_result response side.
// Optional: define MUL_FLUSH_EN to add the `flush` input, which kills every
//        in-flight op (including one accepted in the same cycle).
module mul_booth_wallace_pipe
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
`ifdef MUL_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  logic [COL_N-1:0][PP_N-1:0] cols;
  pp_row_t                    k_vec, s_vec, c_vec;
  s1_reg_t                    s1_q;
  logic [2:1]                 vld_pipe;  // [1] stage-1 reg, [2] result reg
  logic                       accept, s2_adv, kill;

`ifdef MUL_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  booth_pp_switch u_pp (
    .op   (mul_op_t'(in_op)),
    .src1 (in_src1),
    .src2 (in_src2),
    .cols (cols),
    .k    (k_vec)
  );

  // Each column's carries feed the next column up; column 0 starts from zero.
  for (genvar j = 0; j < COL_N; j++) begin : g_col
    logic [CARRY_N-1:0] cin, cout;
    if (j == 0) begin : g_first
      assign cin = '0;
    end else begin : g_link
      assign cin = g_col[j-1].cout;
    end
    wallace_tree_ u_wt (
      .a     (cols[j]),
      .c_in  (cin),
      .c_out (cout),
      .s     (s_vec[j]),
      .c     (c_vec[j])
    );
  end

  // Top column's carries weigh 2^64 and vanish mod 2^64.
  logic unused_top_cout;
  assign unused_top_cout = ^g_col[COL_N-1].cout;

  assign out_valid = vld_pipe[2];
  assign s2_adv    = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign in_ready  = ~vld_pipe[1] | s2_adv;
  assign accept    = in_valid & in_ready;

  // Stage 2: fold K into the carry-save pair, then one carry-propagate add.
  pp_row_t         c_sh, t_s, t_c, prod;
  logic [XLEN-1:0] res;
  always_comb begin
    c_sh = s1_q.c << 1;
    t_s  = s1_q.s ^ c_sh ^ s1_q.k;
    t_c  = ((s1_q.s & c_sh) | (s1_q.s & s1_q.k) | (c_sh & s1_q.k)) << 1;
    prod = t_s + t_c;
    res  = (s1_q.op == OP_MUL) ? prod[XLEN-1:0] : prod[COL_N-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      out_result <= '0;
    end else begin
      if (kill) begin
        vld_pipe <= '0;
      end else begin
        if (in_ready)                   vld_pipe[1] <= in_valid;
        if (~vld_pipe[2] | out_ready)   vld_pipe[2] <= vld_pipe[1];
      end
      if (accept) s1_q <= '{s: s_vec, c: c_vec, k: k_vec, op: mul_op_t'(in_op)};
      if (s2_adv) out_result <= res;
    end
  end
endmodule

// File: tb/tb_mul_booth_wallace_pipe.sv
// Self-checking bench for mul_booth_wallace_pipe: directed table, back-to-back
// stream, backpressure, randomized traffic against a plain-arithmetic model,
// async reset mid-flight, and (with MUL_FLUSH_EN) flush.
module tb_mul_booth_wallace_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_src1 = '0, in_src2 = '0, out_result;
`ifdef MUL_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0, hold_vld = 1'b0;
  logic [31:0] hold_val = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  mul_booth_wallace_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MUL_FLUSH_EN
    .flush      (flush),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // Reference: extend per opcode to 64 bits, multiply, pick the word.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: record accepts, check drains in order, check held output stability.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_vld) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", out_result, hold_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else chk("stream_result", out_result, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_src1, in_src2));
      hold_vld = out_valid && !out_ready;
      hold_val = out_result;
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[4] = '{2'b00, 32'd3,         32'd5,         32'd15};
    tbl[5] = '{2'b00, 32'd7,         32'd0,         32'd0};
    tbl[6] = '{2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
    tbl[7] = '{2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed table: one op at a time, checking the two-edge latency.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      tick();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_t1_valid", i), 32'(out_valid), 32'd0);
      tick();
      chk($sformatf("tbl%0d_t2_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_result", i), out_result, tbl[i].exp);
      tick();
    end

    // Back-to-back MUL stream with out_ready high: one result per cycle.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(tbl[4+k].op, tbl[4+k].a, tbl[4+k].b);
      else in_valid = 1'b0;
      tick();
      if (k >= 1) begin
        chk($sformatf("b2b%0d_valid", k-1), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d_result", k-1), out_result, tbl[3+k].exp);
      end
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    tick();

    // Backpressure: consumer stalls, pipe fills after two accepts.
    mon_en = 1'b1;
    out_ready = 1'b0;
    begin
      int accepts = 0;
      for (int c = 0; c < 7; c++) begin
        drive(2'($urandom), pick(), pick());
        @(negedge clk);
        if (accepts < 2) chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
        else             chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
        if (in_ready) accepts++;
        tick();
      end
    end
    drain();

    // Randomized traffic with random stalls on both sides.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 2'($urandom);
      in_src1   = pick();
      in_src2   = pick();
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Async reset with both stages full: nothing survives.
    mon_en = 1'b0;
    out_ready = 1'b0;
    drive(2'b00, 32'd11, 32'd13);
    tick();
    drive(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_result", out_result, 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef MUL_FLUSH_EN
    // Flush with two ops in flight and a third being accepted.
    out_ready = 1'b0;
    drive(2'b00, 32'd2, 32'd3);
    tick();
    drive(2'b00, 32'd4, 32'd5);
    tick();
    drive(2'b00, 32'd8, 32'd9);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_accepting", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("fl_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    drive(2'b00, 32'd6, 32'd7);
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_after_valid", 32'(out_valid), 32'd1);
    chk("fl_after_result", out_result, 32'd42);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
